// File: rtl/sliding_window_gen.sv
// sliding_window_gen: streams raster pixels through K-1 line buffers into a KxK register window, emitting strided windows with coordinates and an end-of-frame pulse
module sliding_window_gen #(
  parameter int PIXEL_W = 9,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 9,
  parameter int STRIDE  = 1,
  parameter int XW      = $clog2(IMG_W),
  parameter int YW      = $clog2(IMG_H)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pixel_valid_i,
  input  logic                     frame_start_i,
  input  logic [PIXEL_W-1:0]       pixel_in_i,
  output logic [K*K*PIXEL_W-1:0]   window_out_o,
  output logic                     window_valid_o,
  output logic [XW-1:0]            window_x_o,
  output logic [YW-1:0]            window_y_o,
  output logic                     frame_done_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0] state_q, state_d;
  logic [XW-1:0] col_q, col_d, xph_q, xph_d, wx_q, wx_d, cur_col, cur_xph, cur_wx;
  logic [YW-1:0] row_q, row_d, yph_q, yph_d, wy_q, wy_d, cur_row, cur_yph, cur_wy;
  logic acc, col_end, row_end, last, col_ok, row_ok, x_hit, y_hit, gate;
  logic [PIXEL_W-1:0] lb_q [K-1][IMG_W];
  logic [PIXEL_W-1:0] col0 [K];
  logic [PIXEL_W-1:0] win_q [K][K];
  logic [PIXEL_W-1:0] win_d [K][K];
  logic [K*K*PIXEL_W-1:0] win_flat, wout_q;
  logic wv_q, fd_q;
  logic [XW-1:0] wxo_q;
  logic [YW-1:0] wyo_q;
  assign acc     = pixel_valid_i & (frame_start_i | state_q == RUN);
  assign cur_col = frame_start_i ? '0 : col_q;
  assign cur_row = frame_start_i ? '0 : row_q;
  assign cur_xph = frame_start_i ? '0 : xph_q;
  assign cur_yph = frame_start_i ? '0 : yph_q;
  assign cur_wx  = frame_start_i ? '0 : wx_q;
  assign cur_wy  = frame_start_i ? '0 : wy_q;
  assign col_end = cur_col == XW'(IMG_W - 1);
  assign row_end = cur_row == YW'(IMG_H - 1);
  assign last    = col_end & row_end;
  assign col_ok  = cur_col >= XW'(K - 1);
  assign row_ok  = cur_row >= YW'(K - 1);
  assign x_hit   = col_ok & (cur_xph == XW'(STRIDE - 1));
  assign y_hit   = row_ok & (cur_yph == YW'(STRIDE - 1));
  assign gate    = acc & col_ok & row_ok & (cur_xph == '0) & (cur_yph == '0);
  // Phase counters start at zero on the first column/row that can hold a full window
  always_comb begin
    state_d = acc ? (last ? IDLE : RUN) : state_q;
    col_d   = acc ? (col_end ? '0 : cur_col + 1'b1) : col_q;
    xph_d   = acc ? ((col_end | ~col_ok | x_hit) ? '0 : cur_xph + 1'b1) : xph_q;
    wx_d    = acc ? (col_end ? '0 : x_hit ? cur_wx + 1'b1 : cur_wx) : wx_q;
    row_d   = acc ? (col_end ? (row_end ? '0 : cur_row + 1'b1) : cur_row) : row_q;
    yph_d   = acc ? (!col_end ? cur_yph : (row_end | ~row_ok | y_hit) ? '0 : cur_yph + 1'b1) : yph_q;
    wy_d    = acc ? (!col_end ? cur_wy : row_end ? '0 : y_hit ? cur_wy + 1'b1 : cur_wy) : wy_q;
  end
  // Column 0 is the newest column: current pixel on top of the K-1 rows above it
  always_comb begin
    col0[0] = pixel_in_i;
    for (int n = 1; n < K; n++) col0[n] = lb_q[n-1][cur_col];
    for (int n = 0; n < K; n++) win_d[0][n] = acc ? col0[n] : win_q[0][n];
    for (int m = 1; m < K; m++)
      for (int n = 0; n < K; n++) win_d[m][n] = acc ? win_q[m-1][n] : win_q[m][n];
    win_flat = '0;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++) win_flat[(n*K+m)*PIXEL_W +: PIXEL_W] = win_d[m][n];
  end
  // Line buffers are indexed by column so a restarted frame realigns immediately
  always_ff @(posedge clk_i)
    if (acc) begin
      lb_q[0][cur_col] <= pixel_in_i;
      for (int i = 1; i < K-1; i++) lb_q[i][cur_col] <= lb_q[i-1][cur_col];
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      xph_q   <= '0;
      yph_q   <= '0;
      wx_q    <= '0;
      wy_q    <= '0;
      for (int m = 0; m < K; m++)
        for (int n = 0; n < K; n++) win_q[m][n] <= '0;
      wout_q  <= '0;
      wv_q    <= 1'b0;
      wxo_q   <= '0;
      wyo_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      xph_q   <= xph_d;
      yph_q   <= yph_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      win_q   <= win_d;
      wv_q    <= gate;
      fd_q    <= acc & last;
      if (gate) begin
        wout_q <= win_flat;
        wxo_q  <= cur_wx;
        wyo_q  <= cur_wy;
      end
    end
  assign window_out_o   = wout_q;
  assign window_valid_o = wv_q;
  assign window_x_o     = wxo_q;
  assign window_y_o     = wyo_q;
  assign frame_done_o   = fd_q;
endmodule

// File: tb/tb_sliding_window_gen.sv
// tb_sliding_window_gen: directed checks of a 6x6, K=3 window generator at stride 1 and stride 2
module tb_sliding_window_gen;
  localparam int PW = 9, W = 6, H = 6, K = 3, WB = K*K*PW;
  logic clk = 0, rst_n = 0, pv = 0, fs = 0;
  logic [PW-1:0] pix = '0;
  logic [WB-1:0] w1, w2;
  logic v1, v2, d1, d2;
  logic [2:0] x1, y1, x2, y2;
  int ncmp = 0, nbad = 0;
  int r = 0, c = 0;
  logic run = 0;
  logic nx_v1 = 0, nx_v2 = 0, nx_d = 0, c_v1, c_v2, c_d;
  int nx_r = 0, nx_c = 0, c_r, c_c;
  int n1, n2, dn;
  logic [WB-1:0] first1, last1;
  logic [2:0] lx1, ly1;
  logic ldone;
  logic [PW-1:0] nw2 [4];
  logic [5:0] xy2 [4];
  always #5 clk = ~clk;
  sliding_window_gen #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .pixel_valid_i(pv), .frame_start_i(fs), .pixel_in_i(pix),
    .window_out_o(w1), .window_valid_o(v1), .window_x_o(x1), .window_y_o(y1), .frame_done_o(d1));
  sliding_window_gen #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .pixel_valid_i(pv), .frame_start_i(fs), .pixel_in_i(pix),
    .window_out_o(w2), .window_valid_o(v2), .window_x_o(x2), .window_y_o(y2), .frame_done_o(d2));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [WB-1:0] exp_win(input int rr, input int cc);
    logic [WB-1:0] w;
    w = '0;
    for (int n = 0; n < K; n++)
      for (int m = 0; m < K; m++) w[(n*K+m)*PW +: PW] = PW'((rr-n)*W + (cc-m));
    return w;
  endfunction
  task automatic send(input logic v, input logic s);
    logic acc;
    @(posedge clk);
    #1;
    pv = v;
    fs = s;
    acc = v && (s || run);
    if (v && s) begin r = 0; c = 0; end
    pix = acc ? PW'(r*W + c) : 9'h1A5;
    nx_v1 = acc && r >= K-1 && c >= K-1;
    nx_v2 = nx_v1 && (r-(K-1)) % 2 == 0 && (c-(K-1)) % 2 == 0;
    nx_d = acc && r == H-1 && c == W-1;
    nx_r = r;
    nx_c = c;
    if (acc) begin
      run = !(r == H-1 && c == W-1);
      if (c == W-1) begin c = 0; r = (r == H-1) ? 0 : r + 1; end
      else c++;
    end
  endtask
  task automatic frame(input int gap, input int abort_at);
    int n, guard;
    logic v, s, ab;
    n = 0; guard = 0; ab = 0;
    while (n < W*H && guard < 2000) begin
      v = (gap == 0) || ($urandom_range(0, 99) >= gap);
      s = v && (n == 0 || (n == abort_at && !ab));
      if (s && n != 0) ab = 1;
      send(v, s);
      if (v) n = s ? 1 : n + 1;
      guard++;
    end
    chk("frame_budget", guard < 2000, 1);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) send(0, 0);
  endtask
  task automatic clear_stats;
    n1 = 0; n2 = 0; dn = 0; ldone = 0;
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_v1 <= 0; c_v2 <= 0; c_d <= 0; c_r <= 0; c_c <= 0;
    end else begin
      c_v1 <= nx_v1; c_v2 <= nx_v2; c_d <= nx_d; c_r <= nx_r; c_c <= nx_c;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("valid_s1", v1, c_v1);
      chk("valid_s2", v2, c_v2);
      chk("done_s1", d1, c_d);
      chk("done_s2", d2, c_d);
      if (c_v1) begin
        chk("x_s1", x1, c_c - (K-1));
        chk("y_s1", y1, c_r - (K-1));
        chk("win_s1", w1, exp_win(c_r, c_c));
      end
      if (c_v2) begin
        chk("x_s2", x2, (c_c - (K-1)) / 2);
        chk("y_s2", y2, (c_r - (K-1)) / 2);
        chk("win_s2", w2, exp_win(c_r, c_c));
      end
      if (v1) begin
        if (n1 == 0) first1 = w1;
        last1 = w1; lx1 = x1; ly1 = y1; ldone = d1;
        n1++;
      end
      if (v2) begin
        if (n2 < 4) begin nw2[n2] = w2[PW-1:0]; xy2[n2] = {x2, y2}; end
        n2++;
      end
      if (d1) dn++;
    end
  initial begin
    clear_stats();
    #12;
    chk("rst_win", w1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_x", x1, 0);
    chk("rst_y", y1, 0);
    chk("rst_done", d1, 0);
    @(posedge clk); #3; rst_n = 1;
    for (int i = 0; i < 5; i++) send(1, 0);
    idle(3);
    clear_stats();
    frame(0, -1);
    idle(3);
    chk("idle_ignored_s1_count", n1, 16);
    chk("s1_first_e00", first1[0 +: PW], 14);
    chk("s1_first_e20", first1[2*PW +: PW], 12);
    chk("s1_first_e22", first1[8*PW +: PW], 0);
    chk("s1_last_e00", last1[0 +: PW], 35);
    chk("s1_last_x", lx1, 3);
    chk("s1_last_y", ly1, 3);
    chk("s1_last_with_done", ldone, 1);
    chk("s1_done_count", dn, 1);
    chk("s2_count", n2, 4);
    chk("s2_new0", nw2[0], 14);
    chk("s2_new1", nw2[1], 16);
    chk("s2_new2", nw2[2], 26);
    chk("s2_new3", nw2[3], 28);
    chk("s2_xy0", xy2[0], 6'o00);
    chk("s2_xy1", xy2[1], 6'o10);
    chk("s2_xy2", xy2[2], 6'o01);
    chk("s2_xy3", xy2[3], 6'o11);
    clear_stats();
    frame(50, -1);
    idle(3);
    chk("gap_s1_count", n1, 16);
    chk("gap_s2_count", n2, 4);
    chk("gap_done_count", dn, 1);
    chk("gap_last_e00", last1[0 +: PW], 35);
    clear_stats();
    frame(0, 20);
    idle(3);
    chk("abort_s1_count", n1, 4 + 16);
    chk("abort_s2_count", n2, 2 + 4);
    chk("abort_done_count", dn, 1);
    clear_stats();
    for (int i = 0; i < 25; i++) send(1, i == 0);
    @(posedge clk); #3;
    rst_n = 0; pv = 0; fs = 0;
    run = 0; r = 0; c = 0;
    nx_v1 = 0; nx_v2 = 0; nx_d = 0;
    #1;
    chk("arst_win_s1", w1, 0);
    chk("arst_win_s2", w2, 0);
    chk("arst_x_s1", x1, 0);
    chk("arst_y_s1", y1, 0);
    chk("arst_valid_s1", v1, 0);
    chk("arst_done_s1", d1, 0);
    repeat (2) @(posedge clk);
    #3; rst_n = 1;
    clear_stats();
    frame(0, -1);
    idle(3);
    chk("post_rst_s1_count", n1, 16);
    chk("post_rst_s2_count", n2, 4);
    chk("post_rst_done_count", dn, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
